// File: rtl/cache_line_mover.sv
// rtl/cache_line_mover.sv - memory-side line fill / writeback engine for the data cache
//
// Turns the cache FSM's level-held load (line fill) and writeback (dirty
// eviction) requests into word-by-word beats on a strobe/ack memory bus.
// A dirty miss (load and writeback together) runs writeback then fill back to
// back under a single acceptance.
//
// Optional feature macro: CACHE_CRITICAL_WORD_FIRST_EN
//   defined   - fill starts at the word addressed by req_addr and wraps
//   undefined - fill always runs word 0 upward
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   load, writeback      fill / eviction requests (level, held until pulse)
//   req_addr             miss address, any byte within the line
//   wb_addr, wb_line     victim line address (offset ignored) and data, word 0 in LSBs
//   busy                 transfer in progress (IDLE excluded)
//   fill_line            assembled fill line, word 0 in LSBs
//   fill_valid, wb_done  one-cycle completion pulses
//   mem_rd, mem_wr       memory read / write strobes, never both high
//   mem_addr, mem_wdata  word-aligned beat address and write data
//   mem_rdata, mem_ack   read data and beat acknowledge from memory

module cache_line_mover #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic                             writeback,
    input  logic [ADDR_W-1:0]                req_addr,
    input  logic [ADDR_W-1:0]                wb_addr,
    input  logic [DATA_W*WORDS_PER_LINE-1:0] wb_line,
    output logic                             busy,
    output logic [DATA_W*WORDS_PER_LINE-1:0] fill_line,
    output logic                             fill_valid,
    output logic                             wb_done,
    output logic                             mem_rd,
    output logic                             mem_wr,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic [DATA_W-1:0]                mem_rdata,
    input  logic                             mem_ack
);

    localparam int BW     = $clog2(WORDS_PER_LINE);
    localparam int OFF    = $clog2(DATA_W / 8);
    localparam int HI_W   = ADDR_W - BW - OFF;
    localparam int LINE_W = DATA_W * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [BW-1:0]       beat;
    logic [BW-1:0]       fill_start;
    logic [BW-1:0]       fill_idx;
    logic [BW-1:0]       req_word;
    logic [HI_W-1:0]     wb_hi;
    logic [HI_W-1:0]     fill_hi;
    logic [LINE_W-1:0]   wb_data;
    logic [LINE_W-1:0]   fill_line_q;
    logic                pend_fill;
    logic                did_fill;
    logic                wb_done_q;
    logic                last_beat;

    // Offset bits of the victim address never matter; the low req_addr bits
    // only matter when critical-word-first is built in.
    logic unused_bits;
    assign unused_bits = ^{wb_addr[OFF+BW-1:0], req_addr[OFF+BW-1:0]};

    assign req_word  = req_addr[OFF+BW-1:OFF];
    assign last_beat = (beat == BW'(WORDS_PER_LINE - 1));

    // The beat counter always runs 0 upward; the fill word index is that
    // count offset by the captured start word, wrapping modulo the line.
    assign fill_idx  = fill_start + beat;

    assign fill_line = fill_line_q;
    assign wb_done   = wb_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (writeback) begin
                    next_state = S_WB;
                end else if (load) begin
                    next_state = S_FILL;
                end
            end
            S_WB: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {wb_hi, beat, {OFF{1'b0}}};
                mem_wdata = wb_data[int'(beat)*DATA_W +: DATA_W];
                if (mem_ack && last_beat) begin
                    next_state = pend_fill ? S_FILL : S_DONE;
                end
            end
            S_FILL: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {fill_hi, fill_idx, {OFF{1'b0}}};
                if (mem_ack && last_beat) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                fill_valid = did_fill;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat        <= '0;
            fill_start  <= '0;
            wb_hi       <= '0;
            fill_hi     <= '0;
            wb_data     <= '0;
            fill_line_q <= '0;
            pend_fill   <= 1'b0;
            did_fill    <= 1'b0;
            wb_done_q   <= 1'b0;
        end else begin
            wb_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    beat     <= '0;
                    did_fill <= 1'b0;
                    if (writeback || load) begin
                        fill_hi <= req_addr[ADDR_W-1:OFF+BW];
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
                        fill_start <= req_word;
`else
                        fill_start <= '0;
`endif
                    end
                    if (writeback) begin
                        wb_hi     <= wb_addr[ADDR_W-1:OFF+BW];
                        wb_data   <= wb_line;
                        pend_fill <= load;
                    end else begin
                        pend_fill <= 1'b0;
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            // Pulse lands in DONE, or in the first FILL
                            // cycle of a dirty miss.
                            wb_done_q <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    did_fill <= 1'b1;
                    if (mem_ack) begin
                        fill_line_q[int'(fill_idx)*DATA_W +: DATA_W] <= mem_rdata;
                        beat <= beat + 1'b1;
                    end
                end
                S_DONE: begin
                    pend_fill <= 1'b0;
                end
                default: begin
                    beat <= '0;
                end
            endcase
        end
    end

endmodule
